seq_calculator: RTL and testbench

SEQ_CALCULATOR -- requirements
Module: seq_calculator

---
 rtl/calc_pkg.sv | 39 +++
 rtl/calc_divider.sv | 72 +++++++
 rtl/seq_calculator.sv | 203 ++++++++++++++++++++
 tb/tb_seq_calculator.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for seq_calculator: operation codes, FSM state encoding
// and op-decode helpers. Build option CALC_MOD_EN makes optr 100 a legal mod.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDSUB = 3'd1,
    MUL    = 3'd2,
    DIV    = 3'd3,
    DONE   = 3'd4
  } calc_state_e;

  // True for every opcode this build implements.
  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    ok = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
`ifdef CALC_MOD_EN
    ok = ok || (op == OP_MOD);
`endif
    return ok;
  endfunction

  // True for opcodes that use the divider datapath.
  function automatic logic op_is_divmod(input logic [2:0] op);
    logic hit;
    hit = (op == OP_DIV);
`ifdef CALC_MOD_EN
    hit = hit || (op == OP_MOD);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/calc_divider.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles.
// o_quotient/o_remainder show the result of the step in progress and are
// final while o_done is high, so the caller can capture them on that edge.
module calc_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic             r_busy;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CntW-1:0]  r_cnt;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;

  // One restoring step: shift next dividend bit in, subtract if it fits.
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_div};
    w_fits    = ~w_diff[WIDTH];
    w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
    w_last    = (r_cnt == CntW'(WIDTH - 1));
  end

  assign o_busy      = r_busy;
  assign o_done      = r_busy & w_last;
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

  // Load operands on start, then iterate until the last bit is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// Sequential unsigned calculator: add/sub in one cycle, shift-add multiply
// and restoring divide over WIDTH cycles, result held until consumed.
// Define CALC_MOD_EN to implement optr 100 (mod); otherwise it is illegal.
module seq_calculator
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         optr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               sign_flag,
  output logic               err_div0,
  output logic               err_op,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned CntW = $clog2(WIDTH);

  calc_state_e r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_a, r_b;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_sign, r_err_div0, r_err_op;

  logic               w_b_zero;
  logic               w_div_start;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_div_busy, w_div_done;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [2*WIDTH-1:0] w_div_result;

  assign w_b_zero    = (b == '0);
  assign w_div_start = (r_state == IDLE) & in_valid & op_legal(optr) &
                       op_is_divmod(optr) & ~w_b_zero;
  assign w_mul_last  = (r_cnt == CntW'(WIDTH - 1));
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef CALC_MOD_EN
  assign w_div_result = (r_op == OP_MOD) ? {{WIDTH{1'b0}}, w_rem} : {w_rem, w_quo};
`else
  assign w_div_result = {w_rem, w_quo};
`endif

  calc_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_div_start),
    .i_dividend  (a),
    .i_divisor   (b),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state routing and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!op_legal(optr)) begin
            w_state_nxt = DONE;
          end else if ((optr == OP_ADD) || (optr == OP_SUB)) begin
            w_state_nxt = ADDSUB;
          end else if (optr == OP_MUL) begin
            w_state_nxt = MUL;
          end else if (w_b_zero) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = DIV;
          end
        end
      end
      ADDSUB: w_state_nxt = DONE;
      MUL: begin
        if (w_mul_last) begin
          w_state_nxt = DONE;
        end
      end
      DIV: begin
        if (w_div_done) begin
          w_state_nxt = DONE;
        end else if (!w_div_busy) begin
          // Divider lost its operation; recover rather than hang.
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, multiplier iteration, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_ADD;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_sign     <= 1'b0;
      r_err_div0 <= 1'b0;
      r_err_op   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= optr;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
            if (!op_legal(optr)) begin
              r_result <= '0;
              r_err_op <= 1'b1;
            end else if (op_is_divmod(optr) && w_b_zero) begin
              r_result   <= '0;
              r_err_div0 <= 1'b1;
            end
          end
        end
        ADDSUB: begin
          if (r_op == OP_SUB) begin
            if (r_a < r_b) begin
              r_result <= {{WIDTH{1'b0}}, r_b - r_a};
              r_sign   <= 1'b1;
            end else begin
              r_result <= {{WIDTH{1'b0}}, r_a - r_b};
            end
          end else begin
            r_result <= {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
          end
        end
        MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_result <= w_acc_nxt;
          end
        end
        DIV: begin
          if (w_div_done) begin
            r_result <= w_div_result;
          end
        end
        DONE: begin
          // Result stays visible after hand-off; only the flags clear.
          if (out_ready) begin
            r_sign     <= 1'b0;
            r_err_div0 <= 1'b0;
            r_err_op   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign sign_flag = r_sign;
  assign err_div0  = r_err_div0;
  assign err_op    = r_err_op;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed self-checking bench for seq_calculator at WIDTH=4.
module tb_seq_calculator;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   a, b;
  logic [2:0]     optr;
  logic           in_valid, in_ready;
  logic [2*W-1:0] result;
  logic           sign_flag, err_div0, err_op, out_valid, out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_calculator #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .optr      (optr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .sign_flag (sign_flag),
    .err_div0  (err_div0),
    .err_op    (err_op),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operation for a single cycle, then count edges (accept edge
  // is edge 1) until out_valid is seen, bounded.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                        output int lat, output logic rdy_seen);
    @(negedge clk);
    optr = op; a = va; b = vb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      rdy_seen |= in_ready;
      @(negedge clk);
      lat++;
    end
    rdy_seen |= in_ready;
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [2*W-1:0] exp_res,
                          input logic exp_sign, input logic exp_d0, input logic exp_eop,
                          input int exp_lat);
    int   lat;
    logic rdy_seen;
    run_op(op, va, vb, lat, rdy_seen);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_in_ready_busy"}, {31'd0, rdy_seen}, 32'd0);
    chk({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
    chk({tag, "_flags"}, {29'd0, sign_flag, err_div0, err_op},
        {29'd0, exp_sign, exp_d0, exp_eop});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    chk({tag, "_flags_clear"}, {29'd0, sign_flag, err_div0, err_op}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic rdy_seen;
    logic ov_seen;

    rst_n = 1'b0; a = '0; b = '0; optr = 3'b000; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_state", {20'd0, in_ready, out_valid, sign_flag, err_div0, err_op, result},
        {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("add_9_12", 3'b000, 4'd9, 4'd12, 8'd21, 1'b0, 1'b0, 1'b0, 2);
    op_check("sub_8_3", 3'b001, 4'd8, 4'd3, 8'd5, 1'b0, 1'b0, 1'b0, 2);
    op_check("sub_3_8", 3'b001, 4'd3, 4'd8, 8'd5, 1'b1, 1'b0, 1'b0, 2);
    op_check("div0_8_0", 3'b011, 4'd8, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1);
    op_check("mul_15_15", 3'b010, 4'd15, 4'd15, 8'd225, 1'b0, 1'b0, 1'b0, 5);
    op_check("mul_0_9", 3'b010, 4'd0, 4'd9, 8'd0, 1'b0, 1'b0, 1'b0, 5);
    op_check("div_13_4", 3'b011, 4'd13, 4'd4, 8'h13, 1'b0, 1'b0, 1'b0, 5);
    op_check("div_3_7", 3'b011, 4'd3, 4'd7, 8'h30, 1'b0, 1'b0, 1'b0, 5);
`ifdef CALC_MOD_EN
    op_check("mod_13_4", 3'b100, 4'd13, 4'd4, 8'd1, 1'b0, 1'b0, 1'b0, 5);
    op_check("mod_13_0", 3'b100, 4'd13, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1);
`else
    op_check("mod_13_4", 3'b100, 4'd13, 4'd4, 8'd0, 1'b0, 1'b0, 1'b1, 1);
`endif
    op_check("illegal_111", 3'b111, 4'd5, 4'd5, 8'd0, 1'b0, 1'b0, 1'b1, 1);

    // Backpressure: result held, new requests ignored while out_ready is low.
    run_op(3'b000, 4'd5, 4'd6, lat, rdy_seen);
    chk("bp_latency", lat, 2);
    for (int i = 0; i < 10; i++) begin
      optr = 3'b010; a = 4'(i); b = 4'd3; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_hold", {20'd0, out_valid, in_ready, sign_flag, err_div0, err_op, result},
          {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd11});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
    @(negedge clk);
    chk("bp_stay_idle", {30'd0, in_ready, out_valid}, 32'b10);

    // Reset during the second MUL cycle.
    optr = 3'b010; a = 4'd15; b = 4'd15; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {20'd0, in_ready, out_valid, sign_flag, err_div0, err_op, result},
        {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ov_seen |= out_valid;
    end
    chk("rst_no_stale_valid", {31'd0, ov_seen}, 32'd0);
    op_check("mul_6_7_after_rst", 3'b010, 4'd6, 4'd7, 8'd42, 1'b0, 1'b0, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
